mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller owning the HI/LO architectural registers.
- Sits in the E stage beside the ALU.
- Sequences MULT/MULTU/DIV/DIVU over fixed latencies and services MTHI/MTLO writes and HI/LO reads.
- Exports a busy indication that the hazard unit uses to stall D-stage MDU instructions. The HILO value it drives is what gets carried down the pipeline to M/W.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction carries a valid MDU op this cycle.
- md_op  in  4  operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- busy  out  1  operation in flight (registered).
- mdu_stall  out  1  busy | (start & md_op in {MULT, MULTU, DIV, DIVU}); feeds hazard unit.
- hilo_out  out  32  HI when md_op==MFHI, LO otherwise (combinational from registered HI/LO).
- hi  out  32  current HI register.
- lo  out  32  current LO register.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, state IDLE. Reset mid-operation aborts it; no partial commit.
- States: IDLE, RUN.

IDLE:
- start with MULT/MULTU/DIV/DIVU:
  - Compute the 64-bit product or quotient/remainder from a and b into internal result registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- start with MTHI: HI<=a at this edge. MTLO: LO<=a at this edge. No busy.
- MFHI/MFLO and NONE: no state change.

RUN:
- Counter decrements each cycle.
- In the cycle where counter==1: commit HI/LO at that edge, return to IDLE, busy=0 the next cycle.
- Timing: start in cycle t gives busy high in cycles t+1 .. t+N, and new HI/LO visible in cycle t+N+1.
- Any start while in RUN is ignored: no operand latch, no MTHI/MTLO write. The hazard unit guarantees this never happens legally.
- hilo_out during RUN reflects the old HI/LO.

Arithmetic:
- MULT: signed 32x32 -> 64; HI = result[63:32], LO = result[31:0].
- MULTU: unsigned 32x32 -> 64, same HI/LO split.
- DIV (signed): LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0, DIV or DIVU): runs the full DIV_CYCLES, then HI/LO stay unchanged.
- Operands are captured at start; later changes on a/b have no effect.

Decomposition:
- Shared constants file: md_op encodings (MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8) and default latencies.
- One sub-module, mdu_arith: combinational 64-bit result generation for the four arithmetic ops, including the divide-by-zero flag.
- mdu_ctrl holds the FSM, counter and HI/LO registers.

Test Plan:
- reset, then MULT a=0xFFFFFFFE (-2), b=3:
  - busy high exactly 5 cycles, mdu_stall high in the start cycle.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI a=0x12345678:
  - HI updates next cycle with no busy.
  - MFHI then gives hilo_out=0x12345678.
  - DIVU with b=0 leaves HI/LO unchanged after 10 busy cycles.
- MULT started, then MTLO and a second MULT asserted during RUN: both ignored, and the result equals the first MULT only.
- Reset asserted in the 3rd busy cycle of a DIV -> next cycle busy=0, HI=LO=0, and no later commit.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared md_op encodings, FSM states and default latencies for the MDU
package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// rtl/mdu_ctrl_arith.sv - combinational 64-bit product / quotient-remainder generation
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;

  // Build every candidate result, then select by op; divides see a non-zero divisor
  // so the zero case never produces X and is instead flagged for the controller.
  always_comb begin
    prod_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u      = {32'd0, a} * {32'd0, b};
    b_safe      = (b == 32'd0) ? 32'd1 : b;
    uq          = a / b_safe;
    ur          = a % b_safe;
    a_mag       = a[31] ? (32'd0 - a) : a;
    b_mag       = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    sq_mag      = a_mag / b_mag;
    sr_mag      = a_mag % b_mag;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    sq          = (a[31] ^ b_safe[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr          = a[31] ? (32'd0 - sr_mag) : sr_mag;
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = is_div_op(op) && (b == 32'd0);
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res_hi = sr;
        res_lo = sq;
      end
      MDU_DIVU: begin
        res_hi = ur;
        res_lo = uq;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide sequencer owning the HI/LO registers
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        mdu_stall,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             dz_q, dz_d;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_dz;

  mdu_arith u_arith (
    .op          (md_op),
    .a           (a),
    .b           (b),
    .res_hi      (arith_hi),
    .res_lo      (arith_lo),
    .div_by_zero (arith_dz)
  );

  // Next-state: accept ops only in IDLE; in RUN count down and commit on the last cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith_op(md_op)) begin
            // Operands are consumed here, so later changes on a/b cannot leak in.
            res_hi_d = arith_hi;
            res_lo_d = arith_lo;
            dz_d     = arith_dz;
            cnt_d    = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d  = ST_RUN;
            busy_d   = 1'b1;
          end else if (md_op == MDU_MTHI) begin
            hi_d = a;
          end else if (md_op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        // Any start seen here is deliberately dropped; the hazard unit stalls it upstream.
        if (cnt_q == CNT_W'(1)) begin
          if (!dz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, staged result and architectural HI/LO; reset abandons any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dz_q     <= dz_d;
    end
  end

  // Stall covers both the op in flight and a new arithmetic op arriving this cycle.
  always_comb begin
    busy      = busy_q;
    mdu_stall = busy_q | (start & is_arith_op(md_op));
    hilo_out  = (md_op == MDU_MFHI) ? hi_q : lo_q;
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule
